mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback steps, drives register file RegRead/RegWrite, memory, ALU-mux and PC-update controls, and stalls on a memory-ready handshake. Also keeps a retired-instruction counter for debug.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
clk  input  1  system clock; state updates on rising edge
rst  input  1  asynchronous active-high reset
opcode  input  6  IR[31:26], sampled in DECODE
mem_ready  input  1  memory completes access this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, RegRead, ALUSrcA  output  1 each  datapath controls
ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
illegal_op  output  1  unknown opcode seen in DECODE
state_o  output  4  current state encoding (debug)
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Moore FSM, 4-bit state register; outputs decoded combinationally from state, except PCWrite/IRWrite in FETCH and illegal_op (also gated by inputs). Outputs not listed for a state are 0.
- Reset (async, any time, incl. mid-access): state=IDLE (0), instr_count=0, all control outputs 0.
- IDLE(0): all 0 -> FETCH next edge after rst deasserts.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; PCWrite=IRWrite=mem_ready. Stay while mem_ready=0; -> DECODE when 1.
- DECODE(2): RegRead=1, ALUSrcA=0, ALUSrcB=11, ALUOp=00. Opcode dispatch: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; others -> FETCH with illegal_op=1 for this cycle (treated as NOP, counted as retired).
- MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD if opcode=100011 else MEMWR.
- MEMRD(4): MemRead=1, IorD=1; wait on mem_ready -> MEMWB.
- MEMWB(5): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR(6): MemWrite=1, IorD=1; wait on mem_ready -> FETCH.
- EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB(8): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP(10): PCWrite=1, PCSource=10 -> FETCH.
- Opcode is held stable by IR (IRWrite only in FETCH); FSM re-reads it in MEMADR.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, j 3 cycles.
- instr_count increments by 1 on every edge where the next state is FETCH and the current state is not IDLE or FETCH; wraps modulo 2^CNT_W.
- mem_ready ignored outside FETCH/MEMRD/MEMWR. Wait states unbounded.
- Unused encodings 11-15 (13-15 with option) -> FETCH, all outputs 0.

Optional Feature:
IMM_ALU_EN: when defined, opcode 001000 (addi) dispatches DECODE -> IMMEX(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IMMWB(12): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH (4 cycles, counted). When undefined, 001000 is illegal (illegal_op=1, -> FETCH) and states 11/12 do not exist.

Test Plan:
- Reset: rst=1 mid-MEMRD -> state_o=0, all controls 0, instr_count=0 immediately; first edge after release -> state_o=1, MemRead=1.
- R-type, mem_ready=1, opcode=000000 -> states 1,2,7,8,1; RegRead=1 in 2, ALUOp=10 in 7, RegWrite=1 & RegDst=1 in 8; instr_count 0->1.
- lw with mem_ready low 3 cycles in MEMRD, opcode=100011 -> state 4 held 3 extra cycles, MemRead=IorD=1 throughout, then 5 with MemtoReg=1; total 8 cycles.
- FETCH stall: mem_ready=0 for 2 cycles -> PCWrite=IRWrite=0 while stalled, both 1 only in the cycle mem_ready=1.
- sw then beq then j -> MemWrite=1 in 6; PCWriteCond=1 & PCSource=01 in 9; PCWrite=1 & PCSource=10 in 10; instr_count=3.
- opcode=111111 -> illegal_op=1 for one cycle in DECODE, next state 1, instr_count+1; opcode=001000 -> with IMM_ALU_EN states 11,12 and RegWrite=1 in 12, RegDst=0; without it illegal_op=1.

Source files
------------

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main control FSM with memory-ready stalls and retired-instruction counter
// Optional feature macro: IMM_ALU_EN adds addi (opcode 001000) through states IMMEX(11) and IMMWB(12).
// Ports:
//   clk, rst (async active-high)       clock and reset
//   opcode[5:0], mem_ready              IR[31:26] and memory handshake
//   PCWrite..ALUSrcA, ALUSrcB, ALUOp,   datapath controls
//   PCSource
//   illegal_op                          unknown opcode seen in DECODE
//   state_o[3:0]                        current state (debug)
//   instr_count[CNT_W-1:0]              retired-instruction count
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             RegRead,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP
`ifdef IMM_ALU_EN
    , IMMEX, IMMWB
`endif
  } state_t;
  state_t state, next;
  assign state_o = state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= next;
      // an instruction retires whenever a non-fetch state hands back to FETCH
      if (next == FETCH && state != IDLE && state != FETCH)
        instr_count <= instr_count + CNT_W'(1);
    end
  end
  always_comb begin
    next        = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    RegRead     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        next    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        RegRead = 1'b1;
        ALUSrcB = 2'b11;
        case (opcode)
          6'b100011, 6'b101011: next = MEMADR;
          6'b000000:            next = EXEC;
          6'b000100:            next = BRANCH;
          6'b000010:            next = JUMP;
`ifdef IMM_ALU_EN
          6'b001000:            next = IMMEX;
`endif
          default:              illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next    = (opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        next    = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        next     = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        next    = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef IMM_ALU_EN
      IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next    = IMMWB;
      end
      IMMWB: RegWrite = 1'b1;
`endif
      default: next = FETCH;
    endcase
  end
endmodule
